// File: rtl/dm_pkg.sv
// Shared constants and helpers for the pipelined data memory.
// Holds the maximum read latency, the byte-lane count and the per-lane parity function.
// The parity helper is only referenced when DM_PARITY_EN is defined.
package dm_pkg;

  localparam int LAT_MAX = 4;

  // Number of byte lanes in a data word.
  function automatic int lanes(input int w);
    return w / 8;
  endfunction

  // Even parity bit for one byte: makes the total count of ones even.
  function automatic logic par8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dm_delay_line.sv
// Valid+payload shift register for the load return path.
// Latency: DEPTH cycles from i_vld to o_vld.
// Backpressure: none; the line advances every cycle.
// Ports: clk, rst (async active-high), i_vld/i_dat in, o_vld/o_dat out.
// The payload only advances behind a valid bit, so o_dat holds the last delivered value.
module dm_delay_line #(
  parameter int DEPTH = 1,
  parameter int PW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  input  logic [PW-1:0] i_dat,
  output logic          o_vld,
  output logic [PW-1:0] o_dat
);

  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_dat [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0] <= i_vld;
      if (i_vld) begin
        r_dat[0] <= i_dat;
      end
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        // Gate the payload on valid so idle cycles never disturb the held output.
        if (r_vld[i-1]) begin
          r_dat[i] <= r_dat[i-1];
        end
      end
    end
  end

  assign o_vld = r_vld[DEPTH-1];
  assign o_dat = r_dat[DEPTH-1];

endmodule

// File: rtl/dm_pipelined.sv
// Single-port data memory for the MEM stage, byte-enable stores, pipelined loads.
// Latency: load data and done appear LAT cycles after the issue cycle; stores are silent.
// Backpressure: none; one access accepted every cycle, no busy output.
// Ports: clka, rst (async active-high), ena, wea[B], addra[N], dina[W] in;
//        douta[W], done, and perr (only when DM_PARITY_EN is defined) out.
// Optional feature macro: DM_PARITY_EN adds per-lane even parity storage and the perr output.
module dm_pipelined
  import dm_pkg::*;
#(
  parameter int N   = 7,
  parameter int W   = 32,
  parameter int LAT = 1
) (
  input  logic               clka,
  input  logic               rst,
  input  logic               ena,
  input  logic [lanes(W)-1:0] wea,
  input  logic [N-1:0]       addra,
  input  logic [W-1:0]       dina,
  output logic [W-1:0]       douta,
`ifdef DM_PARITY_EN
  output logic               done,
  output logic               perr
`else
  output logic               done
`endif
);

  localparam int B     = lanes(W);
  localparam int DEPTH = 2 ** N;
`ifdef DM_PARITY_EN
  localparam int PW = W + 1;
`else
  localparam int PW = W;
`endif

  if (LAT < 1 || LAT > LAT_MAX) begin : g_bad_lat
    $error("dm_pipelined: LAT must be in 1..4");
  end
  if (W % 8 != 0 || W < 8) begin : g_bad_w
    $error("dm_pipelined: W must be a positive multiple of 8");
  end

  // Array is zero at time 0 and deliberately never reset.
  logic [W-1:0] r_mem [DEPTH] = '{default: '0};

  logic          w_ld;
  logic [W-1:0]  w_rd_dat;
  logic [PW-1:0] w_ld_pay;
  logic          w_out_vld;
  logic [PW-1:0] w_out_pay;

  assign w_ld     = ena & ~(|wea);
  assign w_rd_dat = r_mem[addra];

  // A store edge that coincides with reset is dropped.
  always_ff @(posedge clka) begin
    if (!rst && ena) begin
      for (int i = 0; i < B; i++) begin
        if (wea[i]) begin
          r_mem[addra][8*i +: 8] <= dina[8*i +: 8];
        end
      end
    end
  end

`ifdef DM_PARITY_EN
  logic [B-1:0] r_par [DEPTH] = '{default: '0};
  logic         w_rd_err;

  always_ff @(posedge clka) begin
    if (!rst && ena) begin
      for (int i = 0; i < B; i++) begin
        if (wea[i]) begin
          r_par[addra][i] <= par8(dina[8*i +: 8]);
        end
      end
    end
  end

  // Recompute parity on the word being read and flag any lane that disagrees.
  always_comb begin
    w_rd_err = 1'b0;
    for (int i = 0; i < B; i++) begin
      w_rd_err = w_rd_err | (par8(w_rd_dat[8*i +: 8]) != r_par[addra][i]);
    end
  end

  assign w_ld_pay = {w_rd_err, w_rd_dat};
  // Error bit is held with the data, so qualify it with done.
  assign perr     = w_out_vld & w_out_pay[W];
`else
  assign w_ld_pay = w_rd_dat;
`endif

  // Array is sampled at the issue edge into the first stage of the line.
  dm_delay_line #(
    .DEPTH (LAT),
    .PW    (PW)
  ) u_ret (
    .clk   (clka),
    .rst   (rst),
    .i_vld (w_ld),
    .i_dat (w_ld_pay),
    .o_vld (w_out_vld),
    .o_dat (w_out_pay)
  );

  assign done  = w_out_vld;
  assign douta = w_out_pay[W-1:0];

endmodule

// File: tb/tb_dm_pipelined.sv
// Directed bench: three instances (LAT=1,3,4) share one stimulus stream.
// Each instance is checked against its own latency with hand-computed expectations.
module tb_dm_pipelined;

  logic        clka = 1'b0;
  logic        rst;
  logic        ena;
  logic [3:0]  wea;
  logic [6:0]  addra;
  logic [31:0] dina;

  logic [2:0][31:0] dout_v;
  logic [2:0]       done_v;
  logic [2:0]       perr_v;

  int lat_of [3] = '{1, 3, 4};
  int n_vec  = 0;
  int n_miss = 0;

  always #5 clka = ~clka;

  dm_pipelined #(.N(7), .W(32), .LAT(1)) u_l1 (
    .clka (clka), .rst (rst), .ena (ena), .wea (wea), .addra (addra), .dina (dina),
    .douta (dout_v[0]),
    .done  (done_v[0])
`ifdef DM_PARITY_EN
   ,.perr  (perr_v[0])
`endif
  );

  dm_pipelined #(.N(7), .W(32), .LAT(3)) u_l3 (
    .clka (clka), .rst (rst), .ena (ena), .wea (wea), .addra (addra), .dina (dina),
    .douta (dout_v[1]),
    .done  (done_v[1])
`ifdef DM_PARITY_EN
   ,.perr  (perr_v[1])
`endif
  );

  dm_pipelined #(.N(7), .W(32), .LAT(4)) u_l4 (
    .clka (clka), .rst (rst), .ena (ena), .wea (wea), .addra (addra), .dina (dina),
    .douta (dout_v[2]),
    .done  (done_v[2])
`ifdef DM_PARITY_EN
   ,.perr  (perr_v[2])
`endif
  );

`ifndef DM_PARITY_EN
  assign perr_v = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one cycle of inputs, then sample #1 after the edge.
  task automatic step(input logic e, input logic [3:0] w, input logic [6:0] a, input logic [31:0] d);
    ena = e; wea = w; addra = a; dina = d;
    @(posedge clka);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 7'd0, 32'h0);
  endtask

  task automatic chk_quiet(input string tag);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s_done_L%0d", tag, lat_of[j]), {31'd0, done_v[j]}, 32'd0);
      chk($sformatf("%s_dout_L%0d", tag, lat_of[j]), dout_v[j], 32'd0);
    end
  endtask

  // Isolated load: done must pulse after exactly LAT steps counting the issue step.
  task automatic load_check(input string tag, input logic [6:0] a, input logic [31:0] exp);
    step(1'b1, 4'h0, a, 32'h0);
    for (int t = 1; t <= 5; t++) begin
      if (t > 1) idle();
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("%s_done_L%0d_t%0d", tag, lat_of[j], t), {31'd0, done_v[j]},
            {31'd0, t == lat_of[j]});
        if (t == lat_of[j])
          chk($sformatf("%s_dout_L%0d", tag, lat_of[j]), dout_v[j], exp);
        chk($sformatf("%s_perr_L%0d_t%0d", tag, lat_of[j], t), {31'd0, perr_v[j]}, 32'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; wea = 4'h0; addra = '0; dina = '0;
    repeat (2) @(posedge clka);
    #1;
    chk_quiet("reset");
    rst = 1'b0;
    idle();

    // Store then load: no done on the store, then one pulse per instance.
    step(1'b1, 4'hF, 7'd5, 32'hDEADBEEF);
    for (int j = 0; j < 3; j++)
      chk($sformatf("st_nodone_L%0d", lat_of[j]), {31'd0, done_v[j]}, 32'd0);
    load_check("ld5", 7'd5, 32'hDEADBEEF);

    // Byte enables: lanes 0 and 2 take the new bytes.
    step(1'b1, 4'hF, 7'd9, 32'h11223344);
    step(1'b1, 4'b0101, 7'd9, 32'hAABBCCDD);
    load_check("be9", 7'd9, 32'h11BB33DD);

    // Streaming: four back-to-back loads give four back-to-back pulses in order.
    for (int a = 0; a < 4; a++)
      step(1'b1, 4'hF, 7'(a), 32'h10 * (a + 1));
    for (int t = 1; t <= 9; t++) begin
      if (t <= 4) step(1'b1, 4'h0, 7'(t - 1), 32'h0);
      else idle();
      for (int j = 0; j < 3; j++) begin
        logic exp_done;
        exp_done = (t >= lat_of[j]) && (t < lat_of[j] + 4);
        chk($sformatf("strm_done_L%0d_t%0d", lat_of[j], t), {31'd0, done_v[j]}, {31'd0, exp_done});
        if (exp_done)
          chk($sformatf("strm_dout_L%0d_t%0d", lat_of[j], t), dout_v[j],
              32'h10 * (t - lat_of[j] + 1));
      end
    end

    // Read-before-write: load captures the old value even with a store next cycle.
    step(1'b1, 4'hF, 7'd2, 32'h5);
    step(1'b1, 4'h0, 7'd2, 32'h0);
    chk("rbw_dout_L1", dout_v[0], 32'h5);
    chk("rbw_done_L1", {31'd0, done_v[0]}, 32'd1);
    step(1'b1, 4'hF, 7'd2, 32'h7);
    chk("rbw_st_done_L1", {31'd0, done_v[0]}, 32'd0);
    idle();
    chk("rbw_done_L3", {31'd0, done_v[1]}, 32'd1);
    chk("rbw_dout_L3", dout_v[1], 32'h5);
    idle();
    chk("rbw_done_L4", {31'd0, done_v[2]}, 32'd1);
    chk("rbw_dout_L4", dout_v[2], 32'h5);
    idle();
    load_check("rbw_new", 7'd2, 32'h7);

    // Reset mid-flight with a store to addr 5 coincident with reset.
    step(1'b1, 4'h0, 7'd5, 32'h0);
    step(1'b1, 4'h0, 7'd9, 32'h0);
    rst = 1'b1; ena = 1'b1; wea = 4'hF; addra = 7'd5; dina = 32'h0;
    #1;
    chk_quiet("rst_assert");
    @(posedge clka);
    #1;
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      idle();
      chk_quiet($sformatf("rst_after%0d", t));
    end
    load_check("rst_mem5", 7'd5, 32'hDEADBEEF);
    load_check("rst_mem9", 7'd9, 32'h11BB33DD);

`ifdef DM_PARITY_EN
    // Corrupt one stored bit behind the parity bit's back; perr only in the done cycle.
    step(1'b1, 4'hF, 7'd30, 32'h01020304);
    u_l1.r_mem[30][0] = ~u_l1.r_mem[30][0];
    u_l3.r_mem[30][0] = ~u_l3.r_mem[30][0];
    u_l4.r_mem[30][0] = ~u_l4.r_mem[30][0];
    step(1'b1, 4'h0, 7'd30, 32'h0);
    for (int t = 1; t <= 5; t++) begin
      if (t > 1) idle();
      for (int j = 0; j < 3; j++)
        chk($sformatf("perr_L%0d_t%0d", lat_of[j], t), {31'd0, perr_v[j]},
            {31'd0, t == lat_of[j]});
    end
    load_check("par_clean", 7'd5, 32'hDEADBEEF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
